bnn_weight_streamer: RTL and testbench

//   Transmit side of the BNN weight-load port. Accepts one 8-bit weight word per neuron over a

---
 rtl/bnn_weight_streamer.sv | 123 ++++++++++++
 tb/tb_bnn_weight_streamer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_weight_streamer.sv
// Serialises one 8-bit weight word per neuron into two load_en-qualified nibbles
// (low then high) for the BNN weight-load port, counting neurons up to NUM_NEURONS-1.
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 20,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             load_en,
    output logic [3:0]       load_nib,
    output logic [IDX_W-1:0] neuron_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LO,
        ST_HI,
        ST_FIN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_d;
    logic [3:0]       word_hi_q, word_hi_d;
    logic             load_en_d;
    logic [3:0]       load_nib_d;
    logic             done_d;
    logic             is_last;

    assign is_last = (neuron_idx == LAST_IDX);
    assign busy    = (state_q != ST_IDLE);

    // Only the high nibble needs to be held; the low nibble goes straight to load_nib on accept.
    always_comb begin
        state_d    = state_q;
        idx_d      = neuron_idx;
        word_hi_d  = word_hi_q;
        load_en_d  = 1'b0;
        load_nib_d = load_nib;
        done_d     = 1'b0;
        s_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    idx_d   = '0;
                end
            end
            ST_WAIT: begin
                s_ready = !abort;
                if (abort) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else if (s_valid) begin
                    word_hi_d  = s_data[7:4];
                    load_en_d  = 1'b1;
                    load_nib_d = s_data[3:0];
                    state_d    = ST_LO;
                end
            end
            ST_LO: begin
                load_en_d  = 1'b1;
                load_nib_d = word_hi_q;
                state_d    = ST_HI;
            end
            ST_HI: begin
                if (abort || is_last) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = neuron_idx + IDX_W'(1);
                    s_ready = 1'b1;
                    if (s_valid) begin
                        word_hi_d  = s_data[7:4];
                        load_en_d  = 1'b1;
                        load_nib_d = s_data[3:0];
                        state_d    = ST_LO;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!ena) begin
            s_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            neuron_idx <= '0;
            word_hi_q  <= '0;
            load_en    <= 1'b0;
            load_nib   <= '0;
            done       <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            neuron_idx <= idx_d;
            word_hi_q  <= word_hi_d;
            load_en    <= load_en_d;
            load_nib   <= load_nib_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Scoreboard bench for bnn_weight_streamer: stimulus pushes expected nibbles, words and done
// events; a negedge monitor pops them whenever load_en or done is presented.
module tb_bnn_weight_streamer;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, abort, s_valid;
    logic [7:0] s_data;
    logic       s_ready, load_en, busy, done;
    logic [3:0] load_nib;
    logic [4:0] neuron_idx;

    typedef struct packed {
        logic [3:0] nib;
        logic [4:0] idx;
    } nib_t;

    nib_t       exp_nib_q[$];
    logic [7:0] exp_word_q[$];
    logic [4:0] exp_done_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ld_cnt = 0;
    int run = 0;
    int max_run = 0;
    int done_cnt = 0;
    int exp_done_total = 0;
    bit rx_phase = 1'b0;
    logic [3:0] rx_lo = '0;

    bnn_weight_streamer #(.NUM_NEURONS(20), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .load_en(load_en),
        .load_nib(load_nib), .neuron_idx(neuron_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor and receiver model: consumes one nibble per enabled load_en cycle.
    always @(negedge clk) begin
        nib_t e;
        logic [7:0] w;
        if (!rst_n) begin
            rx_phase = 1'b0;
        end else if (ena) begin
            if (load_en) begin
                ld_cnt++;
                run++;
                if (run > max_run) max_run = run;
                if (exp_nib_q.size() == 0) begin
                    check("nib_unexpected", 32'(load_nib), 32'hFFFF);
                end else begin
                    e = exp_nib_q.pop_front();
                    check("nib", 32'(load_nib), 32'(e.nib));
                    check("nib_idx", 32'(neuron_idx), 32'(e.idx));
                end
                if (!rx_phase) begin
                    rx_lo = load_nib;
                end else if (exp_word_q.size() == 0) begin
                    check("rx_word_unexpected", {24'h0, load_nib, rx_lo}, 32'hFFFF);
                end else begin
                    w = exp_word_q.pop_front();
                    check("rx_word", {24'h0, load_nib, rx_lo}, 32'(w));
                end
                rx_phase = !rx_phase;
            end else begin
                run = 0;
            end
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", 32'(neuron_idx), 32'hFFFF);
                end else begin
                    check("done_idx", 32'(neuron_idx), 32'(exp_done_q.pop_front()));
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] w, input logic [4:0] idx);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (s_ready) begin
                exp_nib_q.push_back({w[3:0], idx});
                exp_nib_q.push_back({w[7:4], idx});
                exp_word_q.push_back(w);
                ok = 1'b1;
            end
            tick();
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_done(input logic [4:0] idx);
        exp_done_q.push_back(idx);
        exp_done_total++;
    endtask

    task automatic wait_done();
        int i = 0;
        while (done_cnt < exp_done_total && i < 200) begin
            tick();
            i++;
        end
        check("done_seen", 32'(done_cnt), 32'(exp_done_total));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ends a load from WAIT via abort; done reports the already-advanced index.
    task automatic abort_from_wait(input logic [4:0] idx);
        expect_done(idx);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done();
    endtask

    initial begin
        int l0;
        rst_n = 1'b0; ena = 1'b1; start = 1'b1; abort = 1'b0; s_valid = 1'b0; s_data = '0;

        // 1: reset with start held
        tick(); tick();
        check("rst_load_en", 32'(load_en), 32'd0);
        check("rst_load_nib", 32'(load_nib), 32'd0);
        check("rst_idx", 32'(neuron_idx), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0; rst_n = 1'b1;
        tick();
        check("idle_after_rst", 32'(busy), 32'd0);

        // start seen while ena=0 is not remembered
        ena = 1'b0; start = 1'b1; tick();
        start = 1'b0; ena = 1'b1; tick();
        check("start_ignored_ena0", 32'(busy), 32'd0);

        // 2: single word
        l0 = ld_cnt;
        do_start();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_s_ready", 32'(s_ready), 32'd1);
        send_word(8'hA5, 5'd0);
        s_valid = 1'b0;
        tick(); tick();
        check("single_wait_idx", 32'(neuron_idx), 32'd1);
        abort_from_wait(5'd1);
        check("single_ld_cycles", 32'(ld_cnt - l0), 32'd2);
        check("single_idle", 32'(busy), 32'd0);

        // 3: full back-to-back load
        l0 = ld_cnt; max_run = 0;
        do_start();
        expect_done(5'd19);
        for (int k = 0; k < 20; k++) send_word(8'(k), 5'(k));
        s_valid = 1'b0;
        wait_done();
        check("full_ld_cycles", 32'(ld_cnt - l0), 32'd40);
        check("full_consecutive", 32'(max_run), 32'd40);
        check("full_final_idx", 32'(neuron_idx), 32'd19);
        check("full_idle", 32'(busy), 32'd0);

        // 4: ena low for 3 cycles while the low nibble is on the port
        do_start();
        send_word(8'h3C, 5'd0);
        s_valid = 1'b0;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_load_en", 32'(load_en), 32'd1);
            check("frz_load_nib", 32'(load_nib), 32'hC);
            check("frz_s_ready", 32'(s_ready), 32'd0);
        end
        ena = 1'b1;
        tick(); tick();
        abort_from_wait(5'd1);

        // 5: abort raised during LO of neuron 4
        l0 = ld_cnt;
        do_start();
        expect_done(5'd4);
        for (int k = 0; k < 5; k++) send_word(8'h40 + 8'(k), 5'(k));
        s_valid = 1'b0;
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        wait_done();
        check("abort_ld_cycles", 32'(ld_cnt - l0), 32'd10);
        check("abort_final_idx", 32'(neuron_idx), 32'd4);

        // 6: reset in HI of neuron 7, then restart
        do_start();
        for (int k = 0; k < 8; k++) send_word(8'h80 + 8'(k), 5'(k));
        s_valid = 1'b0;
        tick();
        check("pre_rst_hi_nib", 32'(load_nib), 32'h8);
        rst_n = 1'b0;
        exp_nib_q.delete();
        exp_word_q.delete();
        tick();
        rst_n = 1'b1;
        check("midrst_idx", 32'(neuron_idx), 32'd0);
        check("midrst_load_en", 32'(load_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        do_start();
        send_word(8'h5A, 5'd0);
        s_valid = 1'b0;
        tick(); tick();
        abort_from_wait(5'd1);

        tick(); tick();
        check("nib_q_drained", 32'(exp_nib_q.size()), 32'd0);
        check("word_q_drained", 32'(exp_word_q.size()), 32'd0);
        check("done_q_drained", 32'(exp_done_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
